// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its
// rotating-priority finder.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  // Derived widths for the default configuration
  localparam int OWNER_W = $clog2(DEF_NUM_REQ);
  localparam int CNT_W   = $clog2(DEF_MAX_BURST + 1);

  function automatic int owner_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority finder: first set request at or above
// rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the async FIFO write port
// among NUM_REQ write-domain requesters; honours the FIFO full flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  localparam int OWN_W      = owner_w(NUM_REQ),
  localparam int BCNT_W     = cnt_w(MAX_BURST)
) (
  input  logic                          wclk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          busy,
  output logic [OWN_W-1:0]              owner
);

  arb_state_t        state_q, state_d;
  logic [OWN_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic              pick_found;
  logic [OWN_W-1:0]  pick_idx;
  logic              accept;
  logic              end_burst;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Handshake: a word moves only when the owner requests, the FIFO has room
  // and reset is low; ack is that same strobe steered to the owner.
  assign accept = (state_q == BURST) && req[owner_q] && !full && !rst;

  always_comb begin
    w_en          = accept;
    ack           = '0;
    ack[owner_q]  = accept;
    wdata         = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign busy  = (state_q == BURST);
  assign owner = owner_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    end_burst  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BURST;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (!req[owner_q]) begin
          end_burst = 1'b1;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (req_last[owner_q] || beat_cnt_q == BCNT_W'(MAX_BURST - 1))
            end_burst = 1'b1;
        end
        // Pointer moves past the finished owner so any waiter is next
        if (end_burst) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
